// File: rtl/key_seqmod.sv
// Collects up to four click events (single, double or long) into one packed code and holds it
// for a consumer until the consumer acknowledges it. A sequence closes after an idle gap of TIDLE
// cycles, or as soon as it holds four events.
//
// state   | meaning
// IDLE    | no sequence open; the next event starts a new one
// COLLECT | sequence open; events are appended and the idle gap is timed
// PRESENT | sequence closed; CODE/LEN are held with VALID high until ACK
module key_seqmod #(
  parameter logic [27:0] TIDLE = 28'd50_000_000,
  parameter logic [2:0]  MAXEV = 3'd4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       isSClick,
  input  logic       isDClick,
  input  logic       isLClick,
  input  logic       ACK,
  output logic [7:0] CODE,
  output logic [2:0] LEN,
  output logic       VALID,
  output logic       DROP
);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} stateT;

  stateT       state, stateNext;
  logic [7:0]  codeReg, codeNext;
  logic [2:0]  count, countNext;
  logic [27:0] idleCnt, idleNext;
  logic        dropReg, dropNext;
  logic        isEvent;
  logic [1:0]  evCode;
  logic [7:0]  slotBits;

  // Only one event is taken per cycle; long press beats double, double beats single.
  assign isEvent  = isSClick | isDClick | isLClick;
  assign evCode   = isLClick ? 2'b11 : (isDClick ? 2'b10 : (isSClick ? 2'b01 : 2'b00));
  assign slotBits = {6'b0, evCode} << {count[1:0], 1'b0};

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      codeReg <= 8'h00;
      count   <= 3'd0;
      idleCnt <= 28'd0;
      dropReg <= 1'b0;
    end else begin
      state   <= stateNext;
      codeReg <= codeNext;
      count   <= countNext;
      idleCnt <= idleNext;
      dropReg <= dropNext;
    end
  end

  always_comb begin
    stateNext = state;
    codeNext  = codeReg;
    countNext = count;
    idleNext  = idleCnt;
    dropNext  = 1'b0;
    case (state)
      IDLE: begin
        if (isEvent) begin
          codeNext  = {6'b0, evCode};
          countNext = 3'd1;
          idleNext  = 28'd0;
          stateNext = COLLECT;
        end
      end
      COLLECT: begin
        // A full sequence closes on the edge after its fourth event; anything arriving then is lost.
        if (count == MAXEV) begin
          dropNext  = isEvent;
          idleNext  = 28'd0;
          stateNext = PRESENT;
        end else if (isEvent) begin
          codeNext  = codeReg | slotBits;
          countNext = count + 3'd1;
          idleNext  = 28'd0;
        end else if (idleCnt == TIDLE - 28'd1) begin
          idleNext  = 28'd0;
          stateNext = PRESENT;
        end else begin
          idleNext  = idleCnt + 28'd1;
        end
      end
      PRESENT: begin
        dropNext = isEvent;
        if (ACK) begin
          codeNext  = 8'h00;
          countNext = 3'd0;
          idleNext  = 28'd0;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        codeNext  = 8'h00;
        countNext = 3'd0;
        idleNext  = 28'd0;
      end
    endcase
  end

  assign CODE  = codeReg;
  assign LEN   = count;
  assign VALID = (state == PRESENT);
  assign DROP  = dropReg;

endmodule

// File: tb/tb_key_seqmod.sv
// Bench for key_seqmod with a short idle gap: directed scenarios followed by random click/ack
// traffic, all checked each cycle against an event-queue reference model.
module tb_key_seqmod;
  localparam logic [27:0] TIDLE = 28'd20;
  localparam int          GAP   = 20;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       isSClick, isDClick, isLClick, ACK;
  logic [7:0] CODE;
  logic [2:0] LEN;
  logic       VALID, DROP;

  int total = 0;
  int bad   = 0;

  // Reference model: the open/closed sequence as a queue of event codes.
  int evq[$];
  int gap;
  bit presenting;
  bit expDrop;

  key_seqmod #(.TIDLE(TIDLE), .MAXEV(3'd4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .isSClick(isSClick), .isDClick(isDClick), .isLClick(isLClick), .ACK(ACK),
    .CODE(CODE), .LEN(LEN), .VALID(VALID), .DROP(DROP)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] expCode();
    logic [7:0] c = 8'h00;
    foreach (evq[i]) c = c | (8'(evq[i]) << (2 * i));
    return c;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    check("code",  CODE, expCode());
    check("len",   {5'b0, LEN}, 8'(evq.size()));
    check("valid", {7'b0, VALID}, {7'b0, presenting});
    check("drop",  {7'b0, DROP}, {7'b0, expDrop});
  endtask

  task automatic modelReset();
    evq.delete();
    gap        = 0;
    presenting = 0;
    expDrop    = 0;
  endtask

  task automatic modelStep(input logic s, input logic d, input logic l, input logic a);
    int ev;
    ev      = l ? 3 : (d ? 2 : (s ? 1 : 0));
    expDrop = 0;
    if (presenting) begin
      if (ev != 0) expDrop = 1;
      if (a) begin
        evq.delete();
        presenting = 0;
      end
    end else if (evq.size() == 4) begin
      presenting = 1;
      if (ev != 0) expDrop = 1;
    end else if (ev != 0) begin
      evq.push_back(ev);
      gap = 0;
    end else if (evq.size() > 0) begin
      gap++;
      if (gap == GAP) presenting = 1;
    end
  endtask

  // Called at a falling edge: drive for one cycle, let the rising edge sample, check at the next falling edge.
  task automatic tick(input logic s, input logic d, input logic l, input logic a);
    isSClick = s; isDClick = d; isLClick = l; ACK = a;
    @(posedge CLOCK);
    modelStep(s, d, l, a);
    @(negedge CLOCK);
    isSClick = 0; isDClick = 0; isLClick = 0; ACK = 0;
    checkAll();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0);
  endtask

  task automatic asyncReset();
    RESET = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge CLOCK);
    checkAll();
    RESET = 1'b1;
  endtask

  initial begin
    int n;
    int den;
    isSClick = 0; isDClick = 0; isLClick = 0; ACK = 0;
    RESET = 1'b0;
    modelReset();
    repeat (3) @(negedge CLOCK);
    checkAll();
    RESET = 1'b1;

    // S then D five cycles apart; VALID after the full idle gap.
    tick(1, 0, 0, 0);
    idle(4);
    tick(0, 1, 0, 0);
    n = 0;
    while (!VALID && n < 40) begin
      tick(0, 0, 0, 0);
      n++;
    end
    check("latency_sd", 8'(n), 8'(GAP));
    check("code_sd", CODE, 8'h09);
    tick(0, 0, 0, 1);

    // Four back-to-back events close the sequence without waiting; a later S is dropped.
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    check("valid_full", {7'b0, VALID}, 8'h01);
    check("code_full", CODE, 8'h97);
    tick(1, 0, 0, 0);
    check("drop_full", {7'b0, DROP}, 8'h01);
    check("code_after_drop", CODE, 8'h97);
    tick(0, 0, 0, 0);

    // Long hold in PRESENT, then ACK with a coincident S that must be dropped.
    idle(50);
    check("valid_held", {7'b0, VALID}, 8'h01);
    tick(1, 0, 0, 1);
    check("drop_on_ack", {7'b0, DROP}, 8'h01);
    check("len_on_ack", {5'b0, LEN}, 8'h00);
    idle(3);

    // Simultaneous L and S: one long-press event.
    tick(1, 0, 1, 0);
    check("prio_code", {6'b0, CODE[1:0]}, 8'h03);
    check("prio_len", {5'b0, LEN}, 8'h01);
    idle(GAP);
    tick(0, 0, 0, 1);

    // Event on the timeout cycle wins and restarts the gap.
    tick(1, 0, 0, 0);
    idle(GAP - 1);
    tick(1, 0, 0, 0);
    check("edge_valid", {7'b0, VALID}, 8'h00);
    check("edge_len", {5'b0, LEN}, 8'h02);
    idle(GAP);
    tick(0, 0, 0, 1);

    // Reset mid-COLLECT and mid-PRESENT, then a stray ACK and a fresh sequence.
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    asyncReset();
    tick(0, 0, 1, 0);
    idle(GAP);
    asyncReset();
    tick(0, 0, 0, 1);
    tick(0, 1, 0, 0);
    check("fresh_len", {5'b0, LEN}, 8'h01);
    idle(GAP);
    tick(0, 0, 0, 1);

    // Random traffic alternating dense and sparse click rates.
    for (int blk = 0; blk < 30; blk++) begin
      den = (blk % 2 == 1) ? 4 : 48;
      repeat (100) begin
        tick($urandom_range(0, den - 1) == 0,
             $urandom_range(0, den - 1) == 0,
             $urandom_range(0, den - 1) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
